ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (for example `0xED` set-LEDs, `0xFF` reset) from the host FPGA to the keyboard over the shared open-drain PS/2 clock and data lines. It is the counterpart of the scancode receive path and shares the same pins. The line drivers are instantiated outside this block, and the block controls them only through active-high pull-low enables.

---
 rtl/ps2_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx - host-to-device PS/2 command transmitter.
//
// Sends one command byte to the keyboard over the shared open-drain PS/2
// clock/data pair. The pad drivers live outside this block; it only asserts
// active-high pull-low enables.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data[7:0]    command byte, captured when send is accepted
//   send         request strobe, accepted only while busy=0
//   busy         transfer in progress (through the done/error cycle)
//   done         one-cycle pulse, device acknowledged the byte
//   error        one-cycle pulse, NACK or timeout
//   ps2_clk_in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in  raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   1 pulls the PS/2 clock line low
//   ps2_data_oe  1 pulls the PS/2 data line low
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQ       = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bitn;
   logic [8:0]       frame;        // {parity, d7..d0}

   logic clk_s_p0, clk_s_p1, clk_s_p2;
   logic dat_s_p0, dat_s_p1;
   logic fall;
   logic in_frame;
   logic tmo;

   // Stage p0/p1: two-flop synchronisers; p2: previous synced clock for edge detect.
   // Lines idle high, so the chain resets to 1 to avoid a false falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s_p0 <= 1'b1;
         clk_s_p1 <= 1'b1;
         clk_s_p2 <= 1'b1;
         dat_s_p0 <= 1'b1;
         dat_s_p1 <= 1'b1;
      end else begin
         clk_s_p0 <= ps2_clk_in;
         clk_s_p1 <= clk_s_p0;
         clk_s_p2 <= clk_s_p1;
         dat_s_p0 <= ps2_data_in;
         dat_s_p1 <= dat_s_p0;
      end
   end

   assign fall     = clk_s_p2 & ~clk_s_p1;
   assign in_frame = (state == S_REQ) || (state == S_SHIFT) ||
                     (state == S_ACK) || (state == S_WAIT_IDLE);
   assign tmo      = (cnt == TMO_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bitn        <= '0;
         frame       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               // busy is still high in the done/error cycle, so a send there is dropped
               if (send && !busy) begin
                  frame      <= {~^data, data};
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  cnt        <= '0;
                  state      <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (cnt == INH_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;   // start bit
                  cnt         <= '0;
                  state       <= S_REQ;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (fall) begin
                  ps2_data_oe <= ~frame[0];
                  bitn        <= 4'd1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (fall) begin
                  if (bitn == 4'd10) begin
                     state <= S_ACK;
                  end else begin
                     bitn <= bitn + 4'd1;
                     // bitn here is the index of the next bit: d1..d7, then parity
                     if (bitn <= 4'd8) ps2_data_oe <= ~frame[bitn];
                     else              ps2_data_oe <= 1'b0;   // stop bit
                  end
               end
            end
            S_ACK: begin
               cnt <= cnt + CNT_W'(1);
               if (!dat_s_p1) begin
                  state <= S_WAIT_IDLE;
               end else begin
                  error <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               cnt <= cnt + CNT_W'(1);
               if (clk_s_p1 && dat_s_p1) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Timeout overrides whatever the frame states decided this cycle.
         if (in_frame && tmo) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b1;
            state       <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx - directed bench for ps2_tx with a simple PS/2 device model.
module tb_ps2_tx;

   localparam int INH = 20;
   localparam int TMO = 200;
   localparam int H   = 6;     // device half-period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = 8'h00;
   logic       send = 1'b0;
   logic       busy, done, error;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int total = 0;
   int bad   = 0;
   int n_done = 0, n_err = 0, n_both = 0, n_frames = 0;
   logic busy_q = 1'b0;

   // open-drain wired-AND of host and device
   assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .send(send),
      .busy(busy), .done(done), .error(error),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) n_done++;
      if (error) n_err++;
      if (done && error) n_both++;
      if (busy && !busy_q) n_frames++;
      busy_q = busy;
   end

   task automatic clear_counts();
      n_done = 0; n_err = 0; n_frames = 0;
   endtask

   task automatic do_send(input logic [7:0] d);
      @(posedge clk); #1;
      data = d; send = 1'b1;
      @(posedge clk); #1;
      send = 1'b0;
   endtask

   // Device: samples the start bit before clocking, then d0..d7, parity, stop
   // on rising edges; the 11th clock carries the ACK (ack=1 pulls data low).
   task automatic dev_frame(input logic ack, input logic chk_lat,
                            output logic [10:0] bits, output logic ok);
      int k;
      ok = 1'b1; bits = '0; k = 0;
      while (!(ps2_data_oe && !ps2_clk_oe) && k < 1000) begin
         @(posedge clk); #1; k++;
      end
      total++;
      if (k >= 1000) begin
         bad++; ok = 1'b0;
         $display("FAIL req_wait: request phase not seen, waited %0d cycles, limit 1000", k);
      end
      if (ok) begin
         repeat (3) @(posedge clk); #1;
         bits[0] = ps2_data_in;
         for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            if (i == 1 && chk_lat) begin
               repeat (2) @(posedge clk); #1;
               total++;
               if (ps2_data_oe !== 1'b1) begin
                  bad++; $display("FAIL edge_lat2: data_oe=%b after 2 cycles, want 1", ps2_data_oe);
               end
               @(posedge clk); #1;
               total++;
               if (ps2_data_oe !== 1'b0) begin
                  bad++; $display("FAIL edge_lat3: data_oe=%b after 3 cycles, want 0", ps2_data_oe);
               end
               repeat (H - 3) @(posedge clk); #1;
            end else begin
               repeat (H) @(posedge clk); #1;
            end
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_in;
            repeat (H) @(posedge clk); #1;
         end
         dev_data_low = ack;
         repeat (H) @(posedge clk); #1;
         dev_clk_low = 1'b1;
         repeat (H) @(posedge clk); #1;
         dev_clk_low = 1'b0;
         repeat (2) @(posedge clk); #1;
         dev_data_low = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      total += 5;
      if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error); end
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_frame_ed();
      logic [10:0] bits;
      logic ok;
      int k;
      clear_counts();
      do_send(8'hED);
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL accept_busy: got %b want 1", busy); end
      if (ps2_clk_oe !== 1'b1) begin bad++; $display("FAIL accept_clk_oe: got %b want 1", ps2_clk_oe); end
      data = 8'h00;   // latched copy must be used from here on
      k = 0;
      while (ps2_clk_oe && k < 1000) begin k++; @(posedge clk); #1; end
      total += 2;
      if (k !== INH) begin bad++; $display("FAIL inhibit_len: got %0d cycles want %0d", k, INH); end
      if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL req_data_oe: got %b want 1", ps2_data_oe); end
      dev_frame(1'b1, 1'b1, bits, ok);
      k = 0;
      while (n_done == 0 && k < 50) begin @(posedge clk); #1; k++; end
      repeat (2) @(posedge clk); #1;
      total += 4;
      if (bits !== 11'b1_1_1110_1101_0) begin bad++; $display("FAIL ed_bits: got %b want 11111101101", bits); end
      if (n_done !== 1) begin bad++; $display("FAIL ed_done: got %0d pulses want 1", n_done); end
      if (n_err !== 0) begin bad++; $display("FAIL ed_error: got %0d pulses want 0", n_err); end
      if (busy !== 1'b0) begin bad++; $display("FAIL ed_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_parity();
      logic [7:0] d_tab [3] = '{8'h01, 8'h00, 8'hFF};
      logic       p_tab [3] = '{1'b0, 1'b1, 1'b1};
      logic [10:0] bits;
      logic ok;
      for (int t = 0; t < 3; t++) begin
         clear_counts();
         do_send(d_tab[t]);
         dev_frame(1'b1, 1'b0, bits, ok);
         repeat (10) @(posedge clk); #1;
         total += 2;
         if (bits !== {1'b1, p_tab[t], d_tab[t], 1'b0}) begin
            bad++; $display("FAIL parity_bits_%h: got %b want %b", d_tab[t], bits, {1'b1, p_tab[t], d_tab[t], 1'b0});
         end
         if (n_done !== 1) begin bad++; $display("FAIL parity_done_%h: got %0d want 1", d_tab[t], n_done); end
      end
   endtask

   task automatic test_nack();
      logic [10:0] bits;
      logic ok;
      clear_counts();
      do_send(8'hFF);
      dev_frame(1'b0, 1'b0, bits, ok);
      repeat (20) @(posedge clk); #1;
      total += 5;
      if (n_err !== 1) begin bad++; $display("FAIL nack_error: got %0d want 1", n_err); end
      if (n_done !== 0) begin bad++; $display("FAIL nack_done: got %0d want 0", n_done); end
      if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL nack_clk_oe: got %b want 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL nack_data_oe: got %b want 0", ps2_data_oe); end
      if (busy !== 1'b0) begin bad++; $display("FAIL nack_busy: got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      int k;
      clear_counts();
      do_send(8'hED);
      k = 0;
      while (!error && k < 600) begin @(posedge clk); #1; k++; end
      total += 4;
      if (error !== 1'b1) begin bad++; $display("FAIL tmo_seen: error=%b after %0d cycles, want 1", error, k); end
      if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL tmo_clk_oe: got %b want 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL tmo_data_oe: got %b want 0", ps2_data_oe); end
      if (k < INH + TMO) begin bad++; $display("FAIL tmo_early: error after %0d cycles, want >= %0d", k, INH + TMO); end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b want 0", busy); end
      repeat (10) @(posedge clk); #1;
      total += 2;
      if (n_err !== 1) begin bad++; $display("FAIL tmo_count: got %0d want 1", n_err); end
      if (n_done !== 0) begin bad++; $display("FAIL tmo_done: got %0d want 0", n_done); end
   endtask

   task automatic test_busy_guard();
      logic [10:0] bits;
      logic ok;
      clear_counts();
      do_send(8'hED);
      fork
         dev_frame(1'b1, 1'b0, bits, ok);
         begin
            repeat (60) @(posedge clk); #1;
            data = 8'h55; send = 1'b1;
            @(posedge clk); #1;
            send = 1'b0; data = 8'h00;
         end
      join
      repeat (300) @(posedge clk); #1;
      total += 4;
      if (bits !== 11'b1_1_1110_1101_0) begin bad++; $display("FAIL guard_bits: got %b want 11111101101", bits); end
      if (n_frames !== 1) begin bad++; $display("FAIL guard_frames: got %0d want 1", n_frames); end
      if (n_done !== 1) begin bad++; $display("FAIL guard_done: got %0d want 1", n_done); end
      if (n_err !== 0) begin bad++; $display("FAIL guard_error: got %0d want 0", n_err); end
   endtask

   task automatic test_reset_midframe();
      logic [10:0] bits;
      logic ok;
      int k;
      clear_counts();
      do_send(8'hED);
      k = 0;
      while (!(ps2_data_oe && !ps2_clk_oe) && k < 1000) begin @(posedge clk); #1; k++; end
      repeat (3) @(posedge clk); #1;
      for (int i = 1; i <= 5; i++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(posedge clk); #1;
         dev_clk_low = 1'b0;
         if (i < 5) repeat (H) @(posedge clk); #1;
      end
      // fall 5 put d4=0 on the line, so data_oe is high here
      total++;
      if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL mid_pre_data_oe: got %b want 1", ps2_data_oe); end
      #2 rst_n = 1'b0;
      #1;
      total += 4;
      if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_data_oe: got %b want 0", ps2_data_oe); end
      if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_clk_oe: got %b want 0", ps2_clk_oe); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      if ((done | error) !== 1'b0) begin bad++; $display("FAIL mid_rst_pulses: got %b want 0", done | error); end
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      clear_counts();
      do_send(8'hF4);
      dev_frame(1'b1, 1'b0, bits, ok);
      repeat (10) @(posedge clk); #1;
      total += 3;
      if (bits !== 11'b1_0_1111_0100_0) begin bad++; $display("FAIL f4_bits: got %b want 10111101000", bits); end
      if (n_done !== 1) begin bad++; $display("FAIL f4_done: got %0d want 1", n_done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL f4_busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_frame_ed();
      test_parity();
      test_nack();
      test_timeout();
      test_busy_guard();
      test_reset_midframe();
      total++;
      if (n_both !== 0) begin bad++; $display("FAIL done_and_error: overlap %0d cycles want 0", n_both); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
